// File: rtl/param_cpu.sv
// Parametrised multi-cycle CPU with loadable program memory, 3 cycles per instruction (FETCH/EXEC/WB).
// No backpressure: host writes program only in IDLE/HALT; PARAM_CPU_CARRY_EN adds carry, ADC and BCS.
module param_cpu #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 2,
    parameter int PC_W   = 8,
    parameter int IMM_W  = 8,
    localparam int INSTR_W = 4 + 2 * RA_W + IMM_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    output logic [DATA_W-1:0]  alu_out,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [3:0] OP_SUB  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BEQZ = 4'hB;
`ifdef PARAM_CPU_CARRY_EN
    localparam logic [3:0] OP_ADC  = 4'hD;
    localparam logic [3:0] OP_BCS  = 4'hE;
`endif
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]         state;
    logic [INSTR_W-1:0] mem [2**PC_W];
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  regs [2**RA_W];
    logic [DATA_W-1:0]  res, res_q;
    logic               wen, wen_q, upd, take, take_q;

    logic [3:0]         op;
    logic [RA_W-1:0]    rd, rs;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W-1:0]  a, b, imm_ext;

    assign op  = ir[INSTR_W-1 -: 4];
    assign rd  = ir[2*RA_W+IMM_W-1 -: RA_W];
    assign rs  = ir[RA_W+IMM_W-1 -: RA_W];
    assign imm = ir[IMM_W-1:0];
    assign a   = regs[rd];
    assign b   = regs[rs];

    generate
        if (IMM_W >= DATA_W) begin : g_imm_trunc
            assign imm_ext = imm[DATA_W-1:0];
        end else begin : g_imm_zext
            assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
        end
    endgenerate

    assign busy   = (state == S_FETCH) || (state == S_EXEC) || (state == S_WB);
    assign halted = (state == S_HALT);

`ifdef PARAM_CPU_CARRY_EN
    logic              carry, carry_nx;
    logic [DATA_W:0]   wide;
`endif

    always_comb begin
        res  = a;
        wen  = 1'b0;
        upd  = 1'b0;
        take = 1'b0;
`ifdef PARAM_CPU_CARRY_EN
        carry_nx = carry;
        wide     = '0;
`endif
        case (op)
            OP_SUB: begin
`ifdef PARAM_CPU_CARRY_EN
                wide     = {1'b0, a} - {1'b0, b};
                res      = wide[DATA_W-1:0];
                carry_nx = wide[DATA_W];
`else
                res = a - b;
`endif
                wen = 1'b1;
                upd = 1'b1;
            end
            OP_ADD: begin
`ifdef PARAM_CPU_CARRY_EN
                wide     = {1'b0, a} + {1'b0, b};
                res      = wide[DATA_W-1:0];
                carry_nx = wide[DATA_W];
`else
                res = a + b;
`endif
                wen = 1'b1;
                upd = 1'b1;
            end
`ifdef PARAM_CPU_CARRY_EN
            OP_ADC: begin
                wide     = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, carry};
                res      = wide[DATA_W-1:0];
                carry_nx = wide[DATA_W];
                wen      = 1'b1;
                upd      = 1'b1;
            end
            OP_BCS:  take = carry;
`endif
            OP_AND:  begin res = a & b;            wen = 1'b1; upd = 1'b1; end
            OP_OR:   begin res = a | b;            wen = 1'b1; upd = 1'b1; end
            OP_XOR:  begin res = a ^ b;            wen = 1'b1; upd = 1'b1; end
            OP_LDI:  begin res = imm_ext;          wen = 1'b1; upd = 1'b1; end
            OP_MOV:  begin res = b;                wen = 1'b1; upd = 1'b1; end
            OP_SHL:  begin res = {a[DATA_W-2:0], 1'b0}; wen = 1'b1; upd = 1'b1; end
            OP_SHR:  begin res = {1'b0, a[DATA_W-1:1]}; wen = 1'b1; upd = 1'b1; end
            OP_JMP:  take = 1'b1;
            OP_BEQZ: take = (a == '0);
            default: ;
        endcase
    end

    // Program loads are only accepted while the core is parked.
    always_ff @(posedge clock) begin
        if (prog_we && ((state == S_IDLE) || (state == S_HALT)))
            mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            alu_out <= '0;
            ir      <= '0;
            res_q   <= '0;
            wen_q   <= 1'b0;
            take_q  <= 1'b0;
            for (int i = 0; i < 2**RA_W; i++) regs[i] <= '0;
`ifdef PARAM_CPU_CARRY_EN
            carry   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_FETCH;
                S_FETCH: begin
                    ir    <= mem[pc];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (upd) alu_out <= res;
                    res_q  <= res;
                    wen_q  <= wen;
                    take_q <= take;
`ifdef PARAM_CPU_CARRY_EN
                    carry  <= carry_nx;
`endif
                    state  <= S_WB;
                end
                S_WB: begin
                    if (wen_q) regs[rd] <= res_q;
                    if (op == OP_HALT) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                        pc    <= take_q ? imm[PC_W-1:0] : pc + PC_W'(1);
                    end
                end
                S_HALT: if (start) begin
                    pc    <= '0;
                    state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_cpu.sv
// Directed bench for param_cpu: per-instruction expected alu_out/pc/halted scoreboard.
module tb_param_cpu;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [15:0] prog_wdata = '0;
    logic [7:0]  alu_out;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    param_cpu dut (
        .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .alu_out(alu_out), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] alu;
        logic [7:0] pcv;
        logic       hlt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int step = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s step=%0d got=%0h exp=%0h", tag, step, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic load(input logic [7:0] addr, input logic [15:0] word);
        prog_we = 1'b1; prog_addr = addr; prog_wdata = word;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic push(input logic [7:0] alu, input logic [7:0] pcv, input logic hlt);
        exp_t e;
        e.alu = alu; e.pcv = pcv; e.hlt = hlt;
        sb.push_back(e);
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_one();
        exp_t e;
        step++;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty step=%0d got=0 exp=1", step);
        end else begin
            e = sb.pop_front();
            chk("alu_out", 32'(alu_out), 32'(e.alu));
            chk("pc",      32'(pc),      32'(e.pcv));
            chk("halted",  32'(halted),  32'(e.hlt));
            chk("busy",    32'(busy),    32'(!e.hlt));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick(); tick(); tick();
            check_one();
        end
    endtask

    initial begin
        // Reset, then idle with no start.
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_state", {14'd0, pc, alu_out, busy, halted}, 32'd0);
        end

        // LDI/LDI/SUB/HALT from IDLE.
        load(8'd0, ins(4'h6, 2'd0, 2'd0, 8'd5));
        load(8'd1, ins(4'h6, 2'd1, 2'd0, 8'd3));
        load(8'd2, ins(4'h0, 2'd0, 2'd1, 8'd0));
        load(8'd3, ins(4'hF, 2'd0, 2'd0, 8'd0));
        push(8'd5, 8'd1, 1'b0); push(8'd3, 8'd2, 1'b0);
        push(8'd2, 8'd3, 1'b0); push(8'd2, 8'd3, 1'b1);
        go();
        run(4);

        // Restart from HALT: pc back to 0, r0=2 and r1=3 retained.
        load(8'd0, ins(4'h7, 2'd2, 2'd0, 8'd0));
        load(8'd1, ins(4'h7, 2'd2, 2'd1, 8'd0));
        load(8'd2, ins(4'hF, 2'd0, 2'd0, 8'd0));
        push(8'd2, 8'd1, 1'b0); push(8'd3, 8'd2, 1'b0); push(8'd3, 8'd2, 1'b1);
        go();
        run(3);

        // Countdown loop with BEQZ and JMP.
        load(8'd0, ins(4'h6, 2'd0, 2'd0, 8'd3));
        load(8'd1, ins(4'h6, 2'd1, 2'd0, 8'd1));
        load(8'd2, ins(4'h0, 2'd0, 2'd1, 8'd0));
        load(8'd3, ins(4'hB, 2'd0, 2'd0, 8'd5));
        load(8'd4, ins(4'hA, 2'd0, 2'd0, 8'd2));
        load(8'd5, ins(4'hF, 2'd0, 2'd0, 8'd0));
        push(8'd3, 8'd1, 1'b0); push(8'd1, 8'd2, 1'b0);
        push(8'd2, 8'd3, 1'b0); push(8'd2, 8'd4, 1'b0); push(8'd2, 8'd2, 1'b0);
        push(8'd1, 8'd3, 1'b0); push(8'd1, 8'd4, 1'b0); push(8'd1, 8'd2, 1'b0);
        push(8'd0, 8'd3, 1'b0); push(8'd0, 8'd5, 1'b0); push(8'd0, 8'd5, 1'b1);
        go();
        run(11);

        // Logic ops, MOV, rd==rs, shifts, SUB underflow.
        load(8'd0,  ins(4'h6, 2'd0, 2'd0, 8'hC3));
        load(8'd1,  ins(4'h6, 2'd1, 2'd0, 8'h5A));
        load(8'd2,  ins(4'h7, 2'd2, 2'd0, 8'd0));
        load(8'd3,  ins(4'h2, 2'd2, 2'd1, 8'd0));
        load(8'd4,  ins(4'h7, 2'd3, 2'd0, 8'd0));
        load(8'd5,  ins(4'h3, 2'd3, 2'd1, 8'd0));
        load(8'd6,  ins(4'h4, 2'd0, 2'd1, 8'd0));
        load(8'd7,  ins(4'h1, 2'd1, 2'd1, 8'd0));
        load(8'd8,  ins(4'h8, 2'd0, 2'd0, 8'd0));
        load(8'd9,  ins(4'h9, 2'd1, 2'd0, 8'd0));
        load(8'd10, ins(4'h0, 2'd2, 2'd3, 8'd0));
        load(8'd11, ins(4'hF, 2'd0, 2'd0, 8'd0));
        push(8'hC3, 8'd1, 1'b0); push(8'h5A, 8'd2, 1'b0); push(8'hC3, 8'd3, 1'b0);
        push(8'h42, 8'd4, 1'b0); push(8'hC3, 8'd5, 1'b0); push(8'hDB, 8'd6, 1'b0);
        push(8'h99, 8'd7, 1'b0); push(8'hB4, 8'd8, 1'b0); push(8'h32, 8'd9, 1'b0);
        push(8'h5A, 8'd10, 1'b0); push(8'h67, 8'd11, 1'b0); push(8'h67, 8'd11, 1'b1);
        go();
        run(12);

        // PC wrap 255 -> 0, then reset in the EXEC of LDI r1.
        load(8'd0,   ins(4'hA, 2'd0, 2'd0, 8'd254));
        load(8'd254, ins(4'h6, 2'd1, 2'd0, 8'h55));
        load(8'd255, ins(4'h5, 2'd0, 2'd0, 8'd0));
        push(8'h67, 8'd254, 1'b0); push(8'h55, 8'd255, 1'b0);
        push(8'h55, 8'd0, 1'b0);   push(8'h55, 8'd254, 1'b0);
        go();
        run(4);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_alu", 32'(alu_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        tick(); tick();
        chk("rst_stays_idle", 32'(busy), 32'd0);

        // Registers cleared; write with start lands; write while busy ignored.
        load(8'd1, ins(4'h3, 2'd2, 2'd1, 8'd0));
        load(8'd2, ins(4'h3, 2'd2, 2'd0, 8'd0));
        load(8'd3, ins(4'h3, 2'd2, 2'd3, 8'd0));
        load(8'd4, ins(4'hF, 2'd0, 2'd0, 8'd0));
        for (int r = 0; r < 2; r++) begin
            push(8'h11, 8'd1, 1'b0); push(8'h11, 8'd2, 1'b0); push(8'h11, 8'd3, 1'b0);
            push(8'h11, 8'd4, 1'b0); push(8'h11, 8'd4, 1'b1);
        end
        prog_we = 1'b1; prog_addr = 8'd0; prog_wdata = ins(4'h6, 2'd2, 2'd0, 8'h11);
        start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        tick();
        prog_we = 1'b1; prog_addr = 8'd4; prog_wdata = ins(4'h6, 2'd0, 2'd0, 8'hEE);
        tick();
        prog_we = 1'b0;
        tick();
        check_one();
        run(4);
        go();
        run(5);

        // Carry chain: ADD overflow then BCS.
        load(8'd0, ins(4'h6, 2'd0, 2'd0, 8'hFF));
        load(8'd1, ins(4'h6, 2'd1, 2'd0, 8'h01));
        load(8'd2, ins(4'h1, 2'd0, 2'd1, 8'd0));
        load(8'd3, ins(4'hE, 2'd0, 2'd0, 8'd6));
        load(8'd4, ins(4'h6, 2'd2, 2'd0, 8'h44));
        load(8'd5, ins(4'hF, 2'd0, 2'd0, 8'd0));
        load(8'd6, ins(4'h6, 2'd2, 2'd0, 8'h66));
        load(8'd7, ins(4'hF, 2'd0, 2'd0, 8'd0));
        push(8'hFF, 8'd1, 1'b0); push(8'h01, 8'd2, 1'b0); push(8'h00, 8'd3, 1'b0);
`ifdef PARAM_CPU_CARRY_EN
        push(8'h00, 8'd6, 1'b0); push(8'h66, 8'd7, 1'b0); push(8'h66, 8'd7, 1'b1);
`else
        push(8'h00, 8'd4, 1'b0); push(8'h44, 8'd5, 1'b0); push(8'h44, 8'd5, 1'b1);
`endif
        go();
        run(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_cpu.md
Name: param_cpu

Overview:
- Parametrised successor of the team's 8-bit two-register multi-cycle CPU.
- Widens the datapath and the register file, and adds a loadable program memory.
- Adds new behaviour: jumps, a conditional branch, shifts, MOV, HALT and a start/halted handshake.
- Sits as a self-contained compute core; a host loads the program, pulses start and watches halted.

Parameters:
- DATA_W, 8, datapath and register width.
- RA_W, 2, register-address bits; the register file holds 2**RA_W registers.
- PC_W, 8, PC width; program memory depth is 2**PC_W.
- IMM_W, 8, immediate field width; must satisfy IMM_W >= PC_W.
- Local INSTR_W = 4 + 2*RA_W + IMM_W.
- Instruction fields, MSB to LSB: opcode[3:0], rd[RA_W], rs[RA_W], imm[IMM_W].

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; honoured in IDLE/HALT only.
- prog_we  in  1  program-memory write enable.
- prog_addr  in  PC_W  program-memory write address.
- prog_wdata  in  INSTR_W  instruction word to write.
- alu_out  out  DATA_W  last ALU/load result, registered.
- pc  out  PC_W  current program counter.
- busy  out  1  high in FETCH/EXEC/WB.
- halted  out  1  high in HALT.

Behaviour:
- Reset is synchronous, active-high, applied at the clock edge. Reset values: state=IDLE, pc=0, all registers=0, alu_out=0, busy=0, halted=0. Program memory is not cleared. Reset mid-instruction aborts the instruction with no writeback.
- State IDLE: start -> FETCH with pc unchanged (0 after reset).
- State FETCH: ir <= mem[pc]; -> EXEC.
- State EXEC: compute result; alu_out updated per opcode; -> WB.
- State WB: register write, then pc update; -> FETCH, or -> HALT for HALT.
- State HALT: start -> pc<=0, FETCH. Registers retain their values across restart.
- Instruction cost: exactly 3 cycles. busy=1 in FETCH/EXEC/WB.
- prog_we: writes only in IDLE/HALT; ignored while busy. prog_we and start in the same cycle: the write lands, and the first fetch sees the new word.
- Opcodes 0-4: SUB, ADD, AND, OR, XOR of rd op rs.
  - alu_out <= result; rd <= result in WB.
  - Results are modulo 2**DATA_W; no flags.
- Opcode 5, NOP: alu_out holds.
- Opcode 6, LDI: rd <= imm zero-extended or truncated to DATA_W; alu_out <= same value.
- Opcode 7, MOV: rd <= rs; alu_out <= rs.
- Opcode 8, SHL: rd <= rd<<1, LSB 0. Opcode 9, SHR: rd <= rd>>1, logical. Both update alu_out.
- Opcode A, JMP: pc <= imm[PC_W-1:0]; alu_out holds.
- Opcode B, BEQZ: if rd==0 then pc <= imm[PC_W-1:0], else pc+1.
- Opcodes D, E: NOP unless the optional feature is compiled in.
- Opcode F, HALT: pc holds on the HALT address; -> HALT.
- All non-branch, non-HALT instructions: pc <= pc+1, wrapping 2**PC_W-1 -> 0.
- rd==rs is legal: operands are read before the write.

Optional Feature:
- Macro: PARAM_CPU_CARRY_EN.
- Defined:
  - 1-bit carry register, reset 0.
  - ADD/SUB set carry to the carry-out / borrow.
  - Opcode D = ADC: rd <= rd+rs+carry, updating carry.
  - Opcode E = BCS: branch to imm if carry==1.
  - All other opcodes leave carry unchanged.
- Undefined: no carry register; D and E behave as NOP.

Test Plan:
- Reset then idle, no start for 10 cycles -> pc=0, alu_out=0, busy=0, halted=0 throughout.
- Program LDI r0,5; LDI r1,3; SUB r0,r1; HALT, then start -> alu_out 5,3,2; halted asserts 12 cycles after start; r0=2.
- Countdown: LDI r0,3; LDI r1,1; SUB r0,r1 at addr2; BEQZ r0,5; JMP 2; HALT at addr5 -> alu_out 2,1,0; halts at pc=5.
- Write at pc=255 with JMP-free NOP, start from a JMP 255 -> pc wraps to 0. Assert reset mid-EXEC -> registers 0, state IDLE, no writeback.
- prog_we while busy ignored: readback run unchanged. Restart from HALT -> pc=0, registers retained.
- With PARAM_CPU_CARRY_EN: LDI r0,255; LDI r1,1; ADD r0,r1; BCS 6 -> r0=0, carry=1, branch taken. Without the macro: same program, no branch.
